duc_multi: RTL

Multi-channel digital up-converter for the zest_soc DAC path. Each of NCH channels takes a baseband I/Q drive and multiplies it by a shared LO. When compiled in, the LO gets an f/4 quadrant rotation. Each channel has its own slew-limited on/off gain ramp. The channel products are summed and saturated into one DAC word. The block sits between the feedback/drive logic and the DAC interpolator, in a single clock domain.

---
 rtl/duc_multi.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/duc_multi.sv
// Multi-channel digital up-converter: per-channel gain ramps, shared LO, summed and saturated DAC word.
// Optional f/4 LO quadrant rotation is compiled in with `define DUC_FOVER4_EN.
module duc_multi #(
  parameter int DW  = 17,
  parameter int NCH = 2,
  parameter int GW  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              div_state,
  input  logic signed [DW:0]      cosa,
  input  logic signed [DW:0]      sina,
  input  logic [2*DW*NCH-1:0]     drive_iq,
  input  logic [NCH-1:0]          enable,
  input  logic [GW-1:0]           ramp_step,
  input  logic                    sat_clr,
  output logic signed [DW-2:0]    dac_out,
  output logic                    sat,
  output logic                    sat_sticky,
  output logic [2*NCH-1:0]        ch_state,
  output logic                    busy
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    ON        = 2'd2,
    RAMP_DOWN = 2'd3
  } st_e;

  localparam int MW = DW + GW + 2;
  localparam int PW = 2 * DW + 2;
  localparam int SW = DW + 2 + $clog2(NCH);
  localparam logic [GW:0] UNITY = {1'b1, {GW{1'b0}}};
  localparam logic signed [SW-1:0] SAT_HI = SW'((64'sd1 <<< (DW - 2)) - 64'sd1);
  localparam logic signed [SW-1:0] SAT_LO = ~SAT_HI;

  logic signed [DW:0]     c_s, s_s;
  logic signed [DW:0]     c1_q, s1_q, c2_q, s2_q;
  logic [2*DW*NCH-1:0]    drive_q;
  logic signed [DW+1:0]   t_s [NCH];
  logic [NCH-1:0]         ramp_s;
  logic signed [SW-1:0]   sum_s;
  logic signed [DW-2:0]   dac_d;
  logic                   sat_d;

`ifdef DUC_FOVER4_EN
  // LO quadrant rotation; ~ is one's-complement negation
  always_comb begin
    case (div_state)
      2'b00:   begin c_s = cosa;  s_s = sina;  end
      2'b01:   begin c_s = ~sina; s_s = cosa;  end
      2'b10:   begin c_s = ~cosa; s_s = ~sina; end
      2'b11:   begin c_s = sina;  s_s = ~cosa; end
      default: begin c_s = cosa;  s_s = sina;  end
    endcase
  end
`else
  logic unused_div_s;
  assign unused_div_s = ^div_state;

  // LO passes through unrotated
  always_comb begin
    c_s = cosa;
    s_s = sina;
  end
`endif

  genvar k;
  generate
    for (k = 0; k < NCH; k++) begin : g_ch
      st_e                  st_q;
      logic [GW:0]          g_q;
      logic [GW+1:0]        up_sum_s;
      logic [GW:0]          g_up_s, g_dn_s;
      logic                 up_full_s, dn_empty_s;
      logic signed [DW-1:0] i_s, q_s, ig_q, qg_q;
      logic signed [MW-1:0] ip_s, qp_s;
      logic signed [PW-1:0] p_q;

      // saturating ramp arithmetic; a zero step means jump straight to the end point
      always_comb begin
        up_sum_s   = {1'b0, g_q} + {2'b00, ramp_step};
        up_full_s  = (ramp_step == {GW{1'b0}}) || (up_sum_s >= {1'b0, UNITY});
        dn_empty_s = (ramp_step == {GW{1'b0}}) || ({1'b0, ramp_step} >= g_q);
        g_up_s     = up_full_s ? UNITY : up_sum_s[GW:0];
        g_dn_s     = dn_empty_s ? {(GW+1){1'b0}} : (g_q - {1'b0, ramp_step});
      end

      // gain ramp FSM; a reversal keeps the current gain for that cycle
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          st_q <= IDLE;
          g_q  <= {(GW+1){1'b0}};
        end else begin
          case (st_q)
            IDLE: begin
              g_q <= {(GW+1){1'b0}};
              if (enable[k]) st_q <= RAMP_UP;
            end
            RAMP_UP: begin
              if (!enable[k]) begin
                st_q <= RAMP_DOWN;
              end else begin
                g_q <= g_up_s;
                if (up_full_s) st_q <= ON;
              end
            end
            ON: begin
              g_q <= UNITY;
              if (!enable[k]) st_q <= RAMP_DOWN;
            end
            RAMP_DOWN: begin
              if (enable[k]) begin
                st_q <= RAMP_UP;
              end else begin
                g_q <= g_dn_s;
                if (dn_empty_s) st_q <= IDLE;
              end
            end
            default: begin
              st_q <= IDLE;
              g_q  <= {(GW+1){1'b0}};
            end
          endcase
        end
      end

      assign i_s  = drive_q[2*k*DW +: DW];
      assign q_s  = drive_q[2*k*DW+DW +: DW];
      assign ip_s = MW'(i_s) * MW'($signed({1'b0, g_q}));
      assign qp_s = MW'(q_s) * MW'($signed({1'b0, g_q}));

      // S2 gain scaling and S3 complex mix
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ig_q <= {DW{1'b0}};
          qg_q <= {DW{1'b0}};
          p_q  <= {PW{1'b0}};
        end else begin
          ig_q <= DW'(ip_s >>> GW);
          qg_q <= DW'(qp_s >>> GW);
          p_q  <= PW'(ig_q) * PW'(c2_q) + PW'(qg_q) * PW'(s2_q);
        end
      end

      assign t_s[k]           = (DW+2)'(p_q >>> DW);
      assign ch_state[2*k +: 2] = st_q;
      assign ramp_s[k]        = st_q[0];
    end
  endgenerate

  assign busy = |ramp_s;

  // full-width channel sum then clip to the DAC range
  always_comb begin
    sum_s = {SW{1'b0}};
    for (int i = 0; i < NCH; i++) begin
      sum_s = sum_s + SW'(t_s[i]);
    end
    if (sum_s > SAT_HI) begin
      dac_d = SAT_HI[DW-2:0];
      sat_d = 1'b1;
    end else if (sum_s < SAT_LO) begin
      dac_d = SAT_LO[DW-2:0];
      sat_d = 1'b1;
    end else begin
      dac_d = sum_s[DW-2:0];
      sat_d = 1'b0;
    end
  end

  // S1 capture, LO alignment with S2, S4 output word and saturation flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drive_q    <= {(2*DW*NCH){1'b0}};
      c1_q       <= {(DW+1){1'b0}};
      s1_q       <= {(DW+1){1'b0}};
      c2_q       <= {(DW+1){1'b0}};
      s2_q       <= {(DW+1){1'b0}};
      dac_out    <= {(DW-1){1'b0}};
      sat        <= 1'b0;
      sat_sticky <= 1'b0;
    end else begin
      drive_q    <= drive_iq;
      c1_q       <= c_s;
      s1_q       <= s_s;
      c2_q       <= c1_q;
      s2_q       <= s1_q;
      dac_out    <= dac_d;
      sat        <= sat_d;
      sat_sticky <= (sat_sticky | sat_d) & ~sat_clr;
    end
  end

endmodule
